packet_arb_rr: RTL

//  Packet-atomic N:1 AXI-stream arbiter merging result streams (control, BLS12-381, secp256k1, ...)

---
 rtl/packet_arb_rr.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/packet_arb_rr.sv
`default_nettype none
// ============================================================================
// packet_arb_rr : packet-atomic N:1 stream arbiter (round-robin or fixed
//                 priority) with channel tagging and orphan-beat drop.
// Revision      : 1.0
// ============================================================================
module packet_arb_rr #(
  parameter int DAT_BYTS = 8,
  parameter int CTL_BITS = 8,
  parameter int NUM_IN   = 4,
  parameter int MODE     = 0,
  localparam int CH_BITS  = $clog2(NUM_IN),
  localparam int MOD_BITS = $clog2(DAT_BYTS),
  localparam int DAT_BITS = DAT_BYTS * 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_IN-1:0]             i_enb,
  input  logic [NUM_IN-1:0]             i_val,
  input  logic [NUM_IN-1:0]             i_sop,
  input  logic [NUM_IN-1:0]             i_eop,
  input  logic [NUM_IN*DAT_BITS-1:0]    i_dat,
  input  logic [NUM_IN*MOD_BITS-1:0]    i_mod,
  input  logic [NUM_IN*CTL_BITS-1:0]    i_ctl,
  output logic [NUM_IN-1:0]             o_rdy,
  output logic                          o_val,
  output logic                          o_sop,
  output logic                          o_eop,
  output logic [DAT_BITS-1:0]           o_dat,
  output logic [MOD_BITS-1:0]           o_mod,
  output logic [CTL_BITS+CH_BITS-1:0]   o_ctl,
  input  logic                          i_rdy,
  output logic                          o_drop
);

  localparam logic [0:0] c_ST_IDLE = 1'b0;
  localparam logic [0:0] c_ST_LOCK = 1'b1;

  logic [0:0]                   r_state;
  logic [0:0]                   w_state_nxt;
  logic [CH_BITS-1:0]           r_sel;
  logic [CH_BITS-1:0]           r_ptr;
  logic [CH_BITS-1:0]           w_gnt;
  logic                         w_gnt_vld;
  logic [NUM_IN-1:0]            w_req;
  logic [NUM_IN-1:0]            w_orph;
  logic                         w_out_adv;
  logic                         w_acc;
  logic                         w_drop_nxt;

  logic                         w_sel_val;
  logic                         w_sel_sop;
  logic                         w_sel_eop;
  logic [DAT_BITS-1:0]          w_sel_dat;
  logic [MOD_BITS-1:0]          w_sel_mod;
  logic [CTL_BITS-1:0]          w_sel_ctl;

  logic                         r_val;
  logic                         r_sop;
  logic                         r_eop;
  logic [DAT_BITS-1:0]          r_dat;
  logic [MOD_BITS-1:0]          r_mod;
  logic [CTL_BITS+CH_BITS-1:0]  r_ctl;
  logic                         r_drop;

  assign w_req  = i_val & i_sop & i_enb;
  assign w_orph = i_val & ~i_sop;

  // Channel index (base + off) folded back into 0..NUM_IN-1; off <= NUM_IN.
  function automatic logic [CH_BITS-1:0] f_wrap(input logic [CH_BITS-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_IN) s = s - NUM_IN;
    return s[CH_BITS-1:0];
  endfunction

  generate
    if (MODE == 0) begin : g_rr
      // Scan from the farthest candidate to the nearest so the nearest wins.
      always_comb begin
        w_gnt     = '0;
        w_gnt_vld = 1'b0;
        for (int k = NUM_IN; k >= 1; k--) begin
          if (w_req[f_wrap(r_ptr, k)]) begin
            w_gnt     = f_wrap(r_ptr, k);
            w_gnt_vld = 1'b1;
          end
        end
      end
    end else begin : g_fix
      always_comb begin
        w_gnt     = '0;
        w_gnt_vld = 1'b0;
        for (int k = NUM_IN - 1; k >= 0; k--) begin
          if (w_req[k]) begin
            w_gnt     = CH_BITS'(k);
            w_gnt_vld = 1'b1;
          end
        end
      end
    end
  endgenerate

  assign w_sel_val = i_val[r_sel];
  assign w_sel_sop = i_sop[r_sel];
  assign w_sel_eop = i_eop[r_sel];
  assign w_sel_dat = i_dat[r_sel*DAT_BITS +: DAT_BITS];
  assign w_sel_mod = i_mod[r_sel*MOD_BITS +: MOD_BITS];
  assign w_sel_ctl = i_ctl[r_sel*CTL_BITS +: CTL_BITS];

  assign w_out_adv = ~r_val | i_rdy;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= c_ST_IDLE;
      r_sel   <= '0;
      r_ptr   <= CH_BITS'(NUM_IN - 1);
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == c_ST_IDLE) && w_gnt_vld) begin
        r_sel <= w_gnt;
        if (MODE == 0) r_ptr <= w_gnt;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: if (w_gnt_vld) w_state_nxt = c_ST_LOCK;
      c_ST_LOCK: if (w_acc && w_sel_eop) w_state_nxt = c_ST_IDLE;
      default:   w_state_nxt = c_ST_IDLE;
    endcase
  end

  // Only the locked channel is ever back-pressured; orphans are sunk in IDLE.
  always_comb begin
    o_rdy      = '0;
    w_acc      = 1'b0;
    w_drop_nxt = 1'b0;
    case (r_state)
      c_ST_IDLE: begin
        o_rdy      = w_orph;
        w_drop_nxt = |w_orph;
      end
      c_ST_LOCK: begin
        o_rdy[r_sel] = w_out_adv;
        w_acc        = w_sel_val & w_out_adv;
      end
      default: ;
    endcase
    if (i_rst) o_rdy = '0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_val  <= 1'b0;
      r_sop  <= 1'b0;
      r_eop  <= 1'b0;
      r_dat  <= '0;
      r_mod  <= '0;
      r_ctl  <= '0;
      r_drop <= 1'b0;
    end else begin
      r_drop <= w_drop_nxt;
      if (w_acc) begin
        r_val <= 1'b1;
        r_sop <= w_sel_sop;
        r_eop <= w_sel_eop;
        r_dat <= w_sel_dat;
        r_mod <= w_sel_mod;
        r_ctl <= {r_sel, w_sel_ctl};
      end else if (i_rdy) begin
        r_val <= 1'b0;
      end
    end
  end

  assign o_val  = r_val;
  assign o_sop  = r_sop;
  assign o_eop  = r_eop;
  assign o_dat  = r_dat;
  assign o_mod  = r_mod;
  assign o_ctl  = r_ctl;
  assign o_drop = r_drop;

endmodule
`default_nettype wire
